// File: rtl/psx_pad_pkg.sv
// Shared constants for the PlayStation pad scanner: FSM encodings, protocol
// bytes, and where each NES button lives in the pad's two data bytes.
package psx_pad_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_ACKW  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] HDR_ID    = 8'h5A;

  // Bit positions inside data byte 0 (d0) and data byte 1 (d1), active-low.
  localparam int D0_SELECT = 0;
  localparam int D0_START  = 3;
  localparam int D0_UP     = 4;
  localparam int D0_RIGHT  = 5;
  localparam int D0_DOWN   = 6;
  localparam int D0_LEFT   = 7;
  localparam int D1_CIRCLE = 5;
  localparam int D1_CROSS  = 6;

endpackage

// File: rtl/psx_spi_byte.sv
// One SPI mode-3, LSB-first byte exchange. sck idles high, mosi moves on the
// falling edge, miso is captured as sck rises.
module psx_spi_byte #(
  parameter int HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx,
  input  logic       start,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx
);

  localparam int HW = $clog2(HALF + 1);

  // Handshake: start is honoured only while idle and launches one byte using
  // tx (if load is high that cycle) or the last loaded byte; done pulses for
  // one cycle when the byte completes, and rx is valid from that cycle on.
  logic          busy;
  logic          phase_high;
  logic [2:0]    bit_idx;
  logic [HW-1:0] hcnt;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;

  assign rx = rx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      phase_high <= 1'b0;
      bit_idx    <= '0;
      hcnt       <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sck        <= 1'b1;
      mosi       <= 1'b1;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (load) tx_q <= tx;
        if (start) begin
          busy       <= 1'b1;
          sck        <= 1'b0;
          mosi       <= load ? tx[0] : tx_q[0];
          phase_high <= 1'b0;
          hcnt       <= '0;
          bit_idx    <= '0;
        end
      end else if (hcnt == HW'(HALF - 1)) begin
        hcnt <= '0;
        if (!phase_high) begin
          sck        <= 1'b1;
          rx_q       <= {miso, rx_q[7:1]};
          phase_high <= 1'b1;
        end else if (bit_idx == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
          mosi <= 1'b1;
        end else begin
          bit_idx    <= bit_idx + 3'd1;
          sck        <= 1'b0;
          phase_high <= 1'b0;
          mosi       <= tx_q[bit_idx + 3'd1];
        end
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/psx_pad_scanner.sv
// Polls up to four PlayStation pads on a shared bus and presents their
// buttons in NES layout, plus raw data bytes and per-pad presence.
module psx_pad_scanner
  import psx_pad_pkg::*;
#(
  parameter int CLK_HZ  = 25_200_000,
  parameter int SCK_HZ  = 250_000,
  parameter int NPADS   = 2,
  parameter int NDATA   = 6,
  parameter int POLL_HZ = 60,
  parameter int ACK_TO  = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miso,
  input  logic                     ack_n,
  output logic                     sck,
  output logic                     mosi,
  output logic [NPADS-1:0]         sel_n,
  output logic [8*NPADS-1:0]       btn,
  output logic [8*NPADS-1:0]       pressed,
  output logic [8*NDATA*NPADS-1:0] raw,
  output logic [NPADS-1:0]         present,
  output logic                     frame_done
);

  localparam int HALF   = CLK_HZ / (2 * SCK_HZ);
  localparam int TICK   = CLK_HZ / POLL_HZ;
  localparam int NBYTES = 3 + NDATA;
  localparam int CMAX   = (4 * HALF > ACK_TO) ? 4 * HALF : ACK_TO;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int TW     = $clog2(TICK + 1);
  localparam int PW     = (NPADS > 1) ? $clog2(NPADS) : 1;
  localparam int BW     = $clog2(NBYTES + 1);

  logic [2:0]         state;
  logic [PW-1:0]      pad;
  logic [BW-1:0]      byte_idx;
  logic [CW-1:0]      cnt;
  logic [TW-1:0]      tick_cnt;
  logic [1:0]         miso_sync;
  logic [1:0]         ack_sync;
  logic               hdr_ok;
  logic [8*NDATA-1:0] data_q;

  logic               miso_s;
  logic               ack_s;
  logic               tick;
  logic               spi_load;
  logic               spi_start;
  logic               spi_done;
  logic [7:0]         spi_rx;
  logic [7:0]         tx_byte;
  logic               last_byte;
  logic               upd_ok;
  logic               upd_bad;
  logic [8*NDATA-1:0] new_data;
  logic [7:0]         new_btn;

  assign miso_s    = miso_sync[1];
  assign ack_s     = ack_sync[1];
  assign tick      = (tick_cnt == TW'(TICK - 1));
  assign last_byte = (byte_idx == BW'(NBYTES - 1));
  assign spi_load  = (state == ST_SETUP) || (state == ST_GAP);
  assign spi_start = spi_load && (cnt == CW'(2 * HALF - 1));
  assign tx_byte   = (byte_idx == BW'(0)) ? CMD_START :
                     (byte_idx == BW'(1)) ? CMD_POLL  : CMD_IDLE;

  // A pad's result lands in the same cycle the FSM moves to NEXT.
  assign upd_ok  = (state == ST_XFER) && spi_done && last_byte && hdr_ok;
  assign upd_bad = ((state == ST_XFER) && spi_done && last_byte && !hdr_ok) ||
                   ((state == ST_ACKW) && ack_s && (cnt == CW'(ACK_TO - 1)));

  always_comb begin
    new_data = data_q;
    new_data[8*(NDATA-1) +: 8] = spi_rx;
  end

  assign new_btn = {~new_data[D0_RIGHT], ~new_data[D0_LEFT], ~new_data[D0_DOWN],
                    ~new_data[D0_UP], ~new_data[D0_START], ~new_data[D0_SELECT],
                    ~new_data[8 + D1_CROSS], ~new_data[8 + D1_CIRCLE]};

  always_comb begin
    sel_n = '1;
    if ((state == ST_SETUP) || (state == ST_XFER) || (state == ST_ACKW) || (state == ST_GAP))
      sel_n[pad] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_sync <= 2'b11;
      ack_sync  <= 2'b11;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      ack_sync  <= {ack_sync[0], ack_n};
    end
  end

  psx_spi_byte #(.HALF(HALF)) u_byte (
    .clk   (clk),
    .rst   (rst),
    .load  (spi_load),
    .tx    (tx_byte),
    .start (spi_start),
    .miso  (miso_s),
    .sck   (sck),
    .mosi  (mosi),
    .done  (spi_done),
    .rx    (spi_rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pad        <= '0;
      byte_idx   <= '0;
      cnt        <= '0;
      tick_cnt   <= '0;
      hdr_ok     <= 1'b0;
      data_q     <= '0;
      btn        <= '0;
      pressed    <= '0;
      raw        <= '0;
      present    <= '0;
      frame_done <= 1'b0;
    end else begin
      pressed    <= '0;
      frame_done <= 1'b0;
      // Free-running timer; ticks seen outside IDLE are simply ignored.
      tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);

      case (state)
        ST_IDLE: begin
          if (tick) begin
            state    <= ST_SETUP;
            pad      <= '0;
            byte_idx <= '0;
            cnt      <= '0;
            hdr_ok   <= 1'b0;
          end
        end
        ST_SETUP, ST_GAP: begin
          if (cnt == CW'(2 * HALF - 1)) begin
            state <= ST_XFER;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_XFER: begin
          if (spi_done) begin
            if (byte_idx == BW'(2)) hdr_ok <= (spi_rx == HDR_ID);
            for (int k = 0; k < NDATA; k++)
              if (byte_idx == BW'(3 + k)) data_q[8*k +: 8] <= spi_rx;
            state <= last_byte ? ST_NEXT : ST_ACKW;
            cnt   <= '0;
          end
        end
        ST_ACKW: begin
          if (!ack_s) begin
            state    <= ST_GAP;
            cnt      <= '0;
            byte_idx <= byte_idx + BW'(1);
          end else if (cnt == CW'(ACK_TO - 1)) begin
            state <= ST_NEXT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_NEXT: begin
          if (cnt == CW'(4 * HALF - 1)) begin
            cnt <= '0;
            if (pad == PW'(NPADS - 1)) begin
              state      <= ST_IDLE;
              frame_done <= 1'b1;
            end else begin
              state    <= ST_SETUP;
              pad      <= pad + PW'(1);
              byte_idx <= '0;
              hdr_ok   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      for (int p = 0; p < NPADS; p++) begin
        if (pad == PW'(p)) begin
          if (upd_ok) begin
            raw[8*NDATA*p +: 8*NDATA] <= new_data;
            btn[8*p +: 8]             <= new_btn;
            pressed[8*p +: 8]         <= new_btn & ~btn[8*p +: 8];
            present[p]                <= 1'b1;
          end else if (upd_bad) begin
            btn[8*p +: 8] <= '0;
            present[p]    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_psx_pad_scanner.sv
// Directed bench: a behavioural pad on select 0, nothing on select 1, with
// hand-computed expectations for each poll.
module tb_psx_pad_scanner;

  localparam int CLK_HZ  = 25_200_000;
  localparam int SCK_HZ  = 250_000;
  localparam int NPADS   = 2;
  localparam int NDATA   = 2;
  localparam int POLL_HZ = 3150;
  localparam int ACK_TO  = 100;
  localparam int HALF    = 50;
  localparam int TICK    = 8000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     miso = 1'b1;
  logic                     ack_n = 1'b1;
  logic                     sck;
  logic                     mosi;
  logic [NPADS-1:0]         sel_n;
  logic [8*NPADS-1:0]       btn;
  logic [8*NPADS-1:0]       pressed;
  logic [8*NDATA*NPADS-1:0] raw;
  logic [NPADS-1:0]         present;
  logic                     frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psx_pad_scanner #(
    .CLK_HZ(CLK_HZ), .SCK_HZ(SCK_HZ), .NPADS(NPADS),
    .NDATA(NDATA), .POLL_HZ(POLL_HZ), .ACK_TO(ACK_TO)
  ) dut (
    .clk(clk), .rst(rst), .miso(miso), .ack_n(ack_n), .sck(sck), .mosi(mosi),
    .sel_n(sel_n), .btn(btn), .pressed(pressed), .raw(raw), .present(present),
    .frame_done(frame_done)
  );

  // Pad model for select 0: shifts resp[] out LSB first, acks every byte but the last.
  logic [7:0] resp [0:4];
  int pbyte = 0;
  int pbit  = 0;
  event ack_ev;

  always @(negedge sel_n[0]) begin
    pbyte = 0;
    pbit  = 0;
  end
  always @(posedge sel_n[0]) miso = 1'b1;
  always @(negedge sck) if (sel_n[0] == 1'b0 && pbyte < 5) miso = resp[pbyte][pbit];
  always @(posedge sck) begin
    if (sel_n[0] == 1'b0) begin
      if (pbit == 7) begin
        pbit  = 0;
        pbyte = pbyte + 1;
        if (pbyte < 5) -> ack_ev;
      end else begin
        pbit = pbit + 1;
      end
    end
  end
  always begin
    @(ack_ev);
    repeat (60) @(negedge clk);
    ack_n = 1'b0;
    repeat (10) @(negedge clk);
    ack_n = 1'b1;
  end

  // Per-poll observations gathered by run_poll.
  int         start_wait;
  int         press_cycles;
  int         sel1_low;
  int         fd_count;
  logic [7:0] snap_btn0;
  logic [7:0] snap_pressed0;
  logic [1:0] snap_present;
  logic [15:0] snap_raw0;
  logic [7:0] pressed_next0;
  logic [1:0] end_present;
  logic [15:0] end_btn;

  task automatic run_poll();
    int n;
    logic prev0;
    logic snapped;
    logic take_next;
    press_cycles = 0;
    sel1_low     = 0;
    fd_count     = 0;
    snapped      = 1'b0;
    take_next    = 1'b0;
    n = 0;
    while (sel_n[0] && n < 2 * TICK) begin
      @(negedge clk);
      n++;
    end
    start_wait = n;
    if (sel_n[0]) begin
      total++; bad++;
      $display("FAIL poll_start: no select after %0d cycles", n);
      return;
    end
    prev0 = 1'b0;
    n = 0;
    while (!frame_done && n < 20000) begin
      @(negedge clk);
      n++;
      if (pressed != '0) press_cycles++;
      if (!sel_n[1]) sel1_low++;
      if (take_next) begin
        pressed_next0 = pressed[7:0];
        take_next = 1'b0;
      end
      if (!prev0 && sel_n[0] && !snapped) begin
        snap_btn0     = btn[7:0];
        snap_pressed0 = pressed[7:0];
        snap_present  = present;
        snap_raw0     = raw[15:0];
        snapped       = 1'b1;
        take_next     = 1'b1;
      end
      prev0 = sel_n[0];
    end
    if (!frame_done) begin
      total++; bad++;
      $display("FAIL poll_end: no frame_done after %0d cycles", n);
      return;
    end
    fd_count    = 1;
    end_present = present;
    end_btn     = btn;
    repeat (4) begin
      @(negedge clk);
      if (frame_done) fd_count++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (sck !== 1'b1) begin bad++; $display("FAIL reset_sck: got %b want 1", sck); end
    total++; if (mosi !== 1'b1) begin bad++; $display("FAIL reset_mosi: got %b want 1", mosi); end
    total++; if (sel_n !== 2'b11) begin bad++; $display("FAIL reset_sel_n: got %b want 11", sel_n); end
    total++; if (btn !== '0) begin bad++; $display("FAIL reset_btn: got %h want 0", btn); end
    total++; if (pressed !== '0) begin bad++; $display("FAIL reset_pressed: got %h want 0", pressed); end
    total++; if (raw !== '0) begin bad++; $display("FAIL reset_raw: got %h want 0", raw); end
    total++; if (present !== '0) begin bad++; $display("FAIL reset_present: got %b want 0", present); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_first_poll();
    resp[0] = 8'hFF; resp[1] = 8'h41; resp[2] = 8'h5A; resp[3] = 8'hEF; resp[4] = 8'hBF;
    run_poll();
    total++; if (start_wait != TICK) begin bad++; $display("FAIL first_tick: got %0d want %0d", start_wait, TICK); end
    total++; if (snap_btn0 !== 8'h12) begin bad++; $display("FAIL first_btn: got %h want 12", snap_btn0); end
    total++; if (snap_pressed0 !== 8'h12) begin bad++; $display("FAIL first_pressed: got %h want 12", snap_pressed0); end
    total++; if (snap_present[0] !== 1'b1) begin bad++; $display("FAIL first_present: got %b want 1", snap_present[0]); end
    total++; if (snap_raw0 !== 16'hBFEF) begin bad++; $display("FAIL first_raw: got %h want bfef", snap_raw0); end
    total++; if (pressed_next0 !== 8'h00) begin bad++; $display("FAIL first_pressed_len: got %h want 00", pressed_next0); end
    total++; if (press_cycles != 1) begin bad++; $display("FAIL first_press_cycles: got %0d want 1", press_cycles); end
  endtask

  task automatic test_same_answer();
    run_poll();
    total++; if (snap_btn0 !== 8'h12) begin bad++; $display("FAIL same_btn: got %h want 12", snap_btn0); end
    total++; if (press_cycles != 0) begin bad++; $display("FAIL same_press_cycles: got %0d want 0", press_cycles); end
    total++; if (snap_present[0] !== 1'b1) begin bad++; $display("FAIL same_present: got %b want 1", snap_present[0]); end
  endtask

  task automatic test_absent_pad();
    run_poll();
    total++; if (sel1_low != 18 * HALF + 1 + ACK_TO) begin bad++; $display("FAIL absent_sel1_low: got %0d want %0d", sel1_low, 18 * HALF + 1 + ACK_TO); end
    total++; if (end_present !== 2'b01) begin bad++; $display("FAIL absent_present: got %b want 01", end_present); end
    total++; if (end_btn[15:8] !== 8'h00) begin bad++; $display("FAIL absent_btn1: got %h want 00", end_btn[15:8]); end
    total++; if (fd_count != 1) begin bad++; $display("FAIL absent_frame_done: got %0d pulses want 1", fd_count); end
  endtask

  task automatic test_sck_timing();
    int n;
    int setup;
    int rises;
    int width;
    int badw;
    int flips;
    logic prev_sck;
    logic prev_mosi;
    logic [7:0] txb;
    n = 0;
    while (sel_n[0] && n < 2 * TICK) begin
      @(negedge clk);
      n++;
    end
    setup = 0;
    while (sck === 1'b1 && setup < 1000) begin
      setup++;
      @(negedge clk);
    end
    total++; if (setup != 2 * HALF) begin bad++; $display("FAIL sck_setup: got %0d want %0d", setup, 2 * HALF); end
    rises = 0; width = 0; badw = 0; flips = 0; txb = '0; n = 0;
    while (rises < 8 && n < 2000) begin
      if (sck == 1'b0) width++;
      prev_sck  = sck;
      prev_mosi = mosi;
      @(negedge clk);
      n++;
      if (prev_sck == 1'b0 && sck == 1'b1) begin
        if (width != HALF) badw++;
        width = 0;
        if (mosi !== prev_mosi) flips++;
        txb[rises] = mosi;
        rises++;
      end
    end
    total++; if (rises != 8) begin bad++; $display("FAIL sck_pulses: got %0d want 8", rises); end
    total++; if (badw != 0) begin bad++; $display("FAIL sck_width: %0d pulses not %0d cycles, want 0", badw, HALF); end
    total++; if (flips != 0) begin bad++; $display("FAIL mosi_stable: got %0d changes at rise want 0", flips); end
    total++; if (txb !== 8'h01) begin bad++; $display("FAIL mosi_byte0: got %h want 01", txb); end
    n = 0;
    while (!frame_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL sck_poll_end: got %b want 1", frame_done); end
    @(negedge clk);
  endtask

  task automatic test_bad_header();
    resp[2] = 8'h00; resp[3] = 8'h00; resp[4] = 8'h00;
    run_poll();
    total++; if (snap_present[0] !== 1'b0) begin bad++; $display("FAIL badhdr_present: got %b want 0", snap_present[0]); end
    total++; if (snap_btn0 !== 8'h00) begin bad++; $display("FAIL badhdr_btn: got %h want 00", snap_btn0); end
    total++; if (snap_raw0 !== 16'hBFEF) begin bad++; $display("FAIL badhdr_raw: got %h want bfef", snap_raw0); end
    total++; if (press_cycles != 0) begin bad++; $display("FAIL badhdr_press_cycles: got %0d want 0", press_cycles); end
  endtask

  task automatic test_reset_mid_byte();
    int n;
    resp[0] = 8'hFF; resp[1] = 8'h41; resp[2] = 8'h5A; resp[3] = 8'hF7; resp[4] = 8'hDF;
    n = 0;
    while (pbyte != 3 && n < 3 * TICK) begin
      @(negedge clk);
      n++;
    end
    total++; if (pbyte != 3) begin bad++; $display("FAIL midrst_reach: got byte %0d want 3", pbyte); end
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (sel_n !== 2'b11) begin bad++; $display("FAIL midrst_sel_n: got %b want 11", sel_n); end
    total++; if (sck !== 1'b1) begin bad++; $display("FAIL midrst_sck: got %b want 1", sck); end
    total++; if (mosi !== 1'b1) begin bad++; $display("FAIL midrst_mosi: got %b want 1", mosi); end
    total++; if (btn !== '0) begin bad++; $display("FAIL midrst_btn: got %h want 0", btn); end
    total++; if (raw !== '0) begin bad++; $display("FAIL midrst_raw: got %h want 0", raw); end
    total++; if (present !== '0) begin bad++; $display("FAIL midrst_present: got %b want 0", present); end
    total++; if (pressed !== '0 || frame_done !== 1'b0) begin bad++; $display("FAIL midrst_pulses: got %h/%b want 0/0", pressed, frame_done); end
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_resume();
    run_poll();
    total++; if (start_wait != TICK) begin bad++; $display("FAIL resume_tick: got %0d want %0d", start_wait, TICK); end
    total++; if (snap_btn0 !== 8'h09) begin bad++; $display("FAIL resume_btn: got %h want 09", snap_btn0); end
    total++; if (snap_pressed0 !== 8'h09) begin bad++; $display("FAIL resume_pressed: got %h want 09", snap_pressed0); end
    total++; if (snap_raw0 !== 16'hDFF7) begin bad++; $display("FAIL resume_raw: got %h want dff7", snap_raw0); end
    total++; if (end_present !== 2'b01) begin bad++; $display("FAIL resume_present: got %b want 01", end_present); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resp[0] = 8'hFF; resp[1] = 8'hFF; resp[2] = 8'hFF; resp[3] = 8'hFF; resp[4] = 8'hFF;
    test_reset();
    test_first_poll();
    test_same_answer();
    test_absent_pad();
    test_sck_timing();
    test_bad_header();
    test_reset_mid_byte();
    test_resume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psx_pad_scanner.md
PSX_PAD_SCANNER -- requirements
Module: psx_pad_scanner

Interface
REQ-001 Parameter CLK_HZ, default 25_200_000, system clock frequency in Hz.
REQ-002 Parameter SCK_HZ, default 250_000, pad serial clock frequency in Hz.
REQ-003 Parameter NPADS, default 2, range 1..4, number of pads sharing one bus, each with its own select line.
REQ-004 Parameter NDATA, default 6, range 2..6, data bytes read per pad after the 3-byte header.
REQ-005 Parameter POLL_HZ, default 60, rate at which all pads are polled.
REQ-006 Parameter ACK_TO, default 100, ACK wait timeout in clk cycles.
REQ-007 Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- miso  in  1  pad data line, shared.
- ack_n  in  1  pad acknowledge, active-low, shared.
- sck  out  1  serial clock.
- mosi  out  1  command data.
- sel_n  out  NPADS  per-pad select, active-low.
- btn  out  8*NPADS  NES-mapped buttons, active-high; pad p occupies [8p+7:8p].
- pressed  out  8*NPADS  one-cycle rising-edge pulses of btn.
- raw  out  8*NDATA*NPADS  data bytes as received, pad-major, byte 0 in the low bits.
- present  out  NPADS  pad answered with a valid header on its last poll.
- frame_done  out  1  one-cycle pulse after the last pad of a poll.

Function
REQ-008 Bus is SPI mode 3, LSB first: sck idles high; mosi changes on the sck falling edge; miso is sampled on the sck rising edge.
REQ-009 Half-period is HALF=CLK_HZ/(2*SCK_HZ) clk cycles; the default is 50.
REQ-010 A poll tick fires every CLK_HZ/POLL_HZ cycles; a tick arriving while a poll is in progress is dropped, never queued.
REQ-011 FSM states: IDLE, SETUP, XFER, ACKW, GAP, NEXT.
- IDLE -> SETUP on tick, with pad index 0.
- SETUP: assert sel_n[p] for 2*HALF cycles, then go to XFER.
- XFER: shift 8 bits, then go to ACKW.
- ACKW: after a non-final byte, wait for ack_n low, then go to GAP.
- GAP: idle for 2*HALF cycles, then go to XFER for the next byte.
- After the final byte (byte 3+NDATA-1), skip ACKW and go to NEXT.
- NEXT: deassert sel_n, hold 4*HALF cycles, then go to SETUP for pad p+1, or to IDLE with frame_done when p=NPADS-1.
REQ-012 Transmitted bytes are 0x01, 0x42, 0x00, then NDATA bytes of 0x00.
REQ-013 Received byte 1 is the ID byte; received byte 2 SHALL equal 0x5A, otherwise the pad's result is invalid.
REQ-014 ACK timeout: if ack_n is not seen low within ACK_TO cycles in ACKW, abort the pad. Abort deasserts sel_n, marks the result invalid and goes to NEXT.
REQ-015 Valid result: raw, btn, pressed and present for pad p update together in the cycle the pad goes to NEXT; present[p]=1.
REQ-016 Invalid result: present[p]=0, btn for pad p =0, raw for pad p holds its old value, and no pressed pulse is generated.
REQ-017 Button mapping, with data byte 0 = d0 and byte 1 = d1 (both active-low from the pad):
- btn[8p+7..8p] = {~d0[5] Right, ~d0[7] Left, ~d0[6] Down, ~d0[4] Up, ~d0[3] Start, ~d0[0] Select, ~d1[6] Cross=B, ~d1[5] Circle=A}.
REQ-018 pressed = new btn & ~old btn, asserted for one cycle at the update.
REQ-019 Exactly one sel_n bit is low at any time, or none; sel_n is never low outside SETUP..NEXT.
REQ-020 miso and ack_n pass through a 2-flop synchroniser before use.

Reset
REQ-021 While rst is high: state=IDLE, sck=1, mosi=1, sel_n all ones, btn=0, pressed=0, raw=0, present=0, frame_done=0, all counters=0.
REQ-022 rst asserted mid-transfer aborts immediately with the values above; the first poll after release starts one full poll interval later.

Structure
REQ-023 The package psx_pad_pkg holds the FSM state enum, the command bytes 0x01/0x42/0x5A, and the NES bit-index constants.
REQ-024 The byte shifter is a sub-module psx_spi_byte (load, start, done, 8-bit rx), with HALF as its parameter.
REQ-025 The top module holds the poll timer, FSM, pad and byte counters, and the output registers.

Verification
REQ-026 Pad model answers 0xFF,0x41,0x5A,0xEF,0xBF (Up and Cross held) -> btn[7:0]=0x12, present[0]=1, and pressed[7:0]=0x12 for one cycle.
REQ-027 Same answer on the next poll -> btn unchanged, no pressed pulse.
REQ-028 Pad 1 absent: ack_n is never driven, with NPADS=2 -> abort after ACK_TO cycles; present=2'b01, btn[15:8]=0, frame_done pulses once.
REQ-029 Header byte 2=0x00 -> present[0]=0, btn[7:0]=0, raw[47:0] unchanged.
REQ-030 Check sck timing over a full byte -> 8 low pulses, each 50 cycles, at the defaults; mosi stable across every rising edge.
REQ-031 rst pulsed during byte 4 -> same cycle: sel_n all ones, sck=1, all outputs 0; normal polling resumes after release.
